// File: rtl/alu_sched.sv
// Two-requester scheduler for a shared combinational ALU: IDLE -> EXEC -> RESP, one op in flight.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_sched #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [1:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [1:0]   req1_op,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_y,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_id,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic         grant0, grant1, accept;
  logic [W-1:0] alu_a_q, alu_b_q, rsp_data_q;
  logic [1:0]   alu_op_q;
  logic         rsp_id_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
  logic         last_q;
`endif

  // Grants are masked by rst so ready stays low while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !rst) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      grant0 = req0_valid;
      grant1 = req1_valid && !req0_valid;
`else
      if (req0_valid && req1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`endif
    end
  end

  assign accept = grant0 | grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant0;
    req1_ready = grant1;
    rsp_valid  = (state_q == RESP);
    busy       = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      if (accept) begin
        alu_a_q  <= grant1 ? req1_a  : req0_a;
        alu_b_q  <= grant1 ? req1_b  : req0_b;
        alu_op_q <= grant1 ? req1_op : req0_op;
        rsp_id_q <= grant1;
`ifndef ALU_SCHED_FIXED_PRIO_EN
        last_q   <= grant1;
`endif
      end
      if (state_q == EXEC) rsp_data_q <= alu_y;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: expected results queued at acceptance, compared at response.
module tb_alu_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic [3:0] alu_a, alu_b, alu_y, rsp_data;
  logic [1:0] alu_op;
  logic       rsp_valid, rsp_ready, rsp_id, busy;

  typedef struct {
    logic [3:0] data;
    logic       id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  alu_sched #(.W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Environment ALU feeding the DUT.
  always_comb begin
    case (alu_op)
      2'b00:   alu_y = alu_a + alu_b;
      2'b01:   alu_y = alu_a - alu_b;
      2'b10:   alu_y = alu_a & alu_b;
      default: alu_y = alu_a | alu_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit id, input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // Holds a request until accepted (bounded); returns at +1 after the acceptance edge.
  task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                       input logic [3:0] exp_data, output bit ok);
    ok = 1'b0;
    drive(id, 1'b1, a, b, op);
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        sb.push_back('{data: exp_data, id: id});
      end
      tick();
    end
    drive(id, 1'b0, a, b, op);
  endtask

  task automatic await_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b1;
    drive(0, 1'b1, 4'd1, 4'd1, 2'b00);
    drive(1, 1'b1, 4'd1, 4'd1, 2'b00);
    #12;
    checks++;
    if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {req0_ready, req1_ready, busy, rsp_valid});
    end
    checks++;
    if ({rsp_data, rsp_id, alu_a, alu_b, alu_op} !== 15'd0) begin
      errors++; $display("FAIL reset_data got %h want 0", {rsp_data, rsp_id, alu_a, alu_b, alu_op});
    end
    drive(0, 1'b0, 4'd0, 4'd0, 2'b00);
    drive(1, 1'b0, 4'd0, 4'd0, 2'b00);
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    bit ok;
    exp_t e;
    drive(0, 1'b1, 4'd3, 4'd5, 2'b00);
    #1;
    checks++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin
      errors++; $display("FAIL add_grant got %b want 100", {req0_ready, req1_ready, busy});
    end
    issue(0, 4'd3, 4'd5, 2'b00, 4'd8, ok);
    checks++;
    if (!ok || {rsp_valid, busy, req0_ready} !== 3'b010 || {alu_a, alu_b, alu_op} !== {4'd3, 4'd5, 2'b00}) begin
      errors++; $display("FAIL add_exec got v%b b%b r%b a%h b%h op%b want v0 b1 r0 a3 b5 op00",
                         rsp_valid, busy, req0_ready, alu_a, alu_b, alu_op);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL add_latency got rsp_valid %b want 1", rsp_valid);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (rsp_data !== e.data || rsp_id !== e.id) begin
        errors++; $display("FAIL add_data got %h/%b want %h/%b", rsp_data, rsp_id, e.data, e.id);
      end
    end
    tick();
    checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL add_done got busy %b valid %b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_ops();
    logic [1:0] ops [3] = '{2'b01, 2'b10, 2'b11};
    logic [3:0] exps[3] = '{4'hE, 4'h1, 4'h7};
    bit ok;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(1, 4'd3, 4'd5, ops[i], exps[i], ok);
      await_rsp(ok);
      checks++;
      if (!ok || sb.size() == 0) begin
        errors++; $display("FAIL ops_timeout op %b got no response want one", ops[i]);
      end else begin
        e = sb.pop_front();
        if (rsp_data !== e.data || rsp_id !== e.id) begin
          errors++; $display("FAIL ops_data op %b got %h/%b want %h/%b", ops[i], rsp_data, rsp_id, e.data, e.id);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic exp_id[4];
    bit   ok;
    exp_t e;
    int   last_cyc;
`ifdef ALU_SCHED_FIXED_PRIO_EN
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    rst = 1'b1; #2; rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) sb.push_back('{data: exp_id[k] ? 4'd5 : 4'd3, id: exp_id[k]});
    drive(0, 1'b1, 4'd1, 4'd2, 2'b00);
    drive(1, 1'b1, 4'd9, 4'd4, 2'b01);
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      await_rsp(ok);
      checks++;
      if (!ok || sb.size() == 0) begin
        errors++; $display("FAIL rr_timeout rsp %0d got none want one", k);
      end else begin
        e = sb.pop_front();
        if (rsp_id !== e.id || rsp_data !== e.data) begin
          errors++; $display("FAIL rr_order rsp %0d got %b/%h want %b/%h", k, rsp_id, rsp_data, e.id, e.data);
        end
        if (k > 0) begin
          checks++;
          if (cyc - last_cyc != 3) begin
            errors++; $display("FAIL rr_gap rsp %0d got %0d cycles want 3", k, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
      end
      if (k == 3) begin
        drive(0, 1'b0, 4'd0, 4'd0, 2'b00);
        drive(1, 1'b0, 4'd0, 4'd0, 2'b00);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    bit   ok;
    exp_t e;
    rsp_ready = 1'b0;
    issue(0, 4'hF, 4'h1, 2'b00, 4'h0, ok);
    await_rsp(ok);
    drive(1, 1'b1, 4'd3, 4'd5, 2'b00);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++; $display("FAIL stall_timeout got no response want one");
      e = '{data: 4'h0, id: 1'b0};
    end else begin
      e = sb.pop_front();
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b1100 || rsp_data !== e.data || rsp_id !== e.id
          || alu_a !== 4'hF) begin
        errors++; $display("FAIL stall_hold cyc %0d got v%b b%b r%b%b d%h id%b a%h want v1 b1 r00 d%h id%b aF",
                           c, rsp_valid, busy, req0_ready, req1_ready, rsp_data, rsp_id, alu_a, e.data, e.id);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({busy, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL stall_release got busy %b req1_ready %b want 0 1", busy, req1_ready);
    end
    issue(1, 4'd3, 4'd5, 2'b00, 4'd8, ok);
    await_rsp(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++; $display("FAIL stall_waiter got no response want one");
    end else begin
      e = sb.pop_front();
      if (rsp_data !== e.data || rsp_id !== e.id) begin
        errors++; $display("FAIL stall_waiter got %h/%b want %h/%b", rsp_data, rsp_id, e.data, e.id);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit   ok;
    exp_t e;
    issue(0, 4'd9, 4'd3, 2'b01, 4'd6, ok);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, rsp_valid, req0_ready, req1_ready} !== 4'b0000 || {rsp_data, rsp_id, alu_a, alu_b, alu_op} !== 15'd0) begin
      errors++; $display("FAIL midreset_async got ctl %b data %h want 0000 0",
                         {busy, rsp_valid, req0_ready, req1_ready}, {rsp_data, rsp_id, alu_a, alu_b, alu_op});
    end
    sb.delete();
    #1 rst = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_discard cyc %0d got rsp_valid %b want 0", c, rsp_valid);
      end
      tick();
    end
    issue(0, 4'd2, 4'd2, 2'b00, 4'd4, ok);
    await_rsp(ok);
    checks++;
    if (!ok || sb.size() == 0) begin
      errors++; $display("FAIL midreset_next got no response want one");
    end else begin
      e = sb.pop_front();
      if (rsp_data !== e.data || rsp_id !== e.id) begin
        errors++; $display("FAIL midreset_next got %h/%b want %h/%b", rsp_data, rsp_id, e.data, e.id);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_round_robin();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 W, default 4, shared ALU operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1 each  requester 0/1 operation accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  W each  operands per requester.
REQ-007 req0_op / req1_op  input  2 each  opcode: 00 add, 01 sub, 10 and, 11 or.
REQ-008 alu_a, alu_b  output  W each  operands driven to the shared combinational ALU.
REQ-009 alu_op  output  2  opcode driven to the shared ALU.
REQ-010 alu_y  input  W  ALU result, combinational from alu_a/alu_b/alu_op.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 rsp_data  output  W  captured ALU result.
REQ-014 rsp_id  output  1  requester that issued the result (0 or 1).
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 Three states: IDLE, EXEC, RESP; exactly one operation in flight at a time.
REQ-017 IDLE: if any reqN_valid is high, grant one requester, assert only its reqN_ready combinationally that cycle, latch its a/b/op and id on the edge, go to EXEC.
REQ-018 reqN_ready is low in EXEC and RESP and for the non-granted requester; a request is accepted only when valid and ready are both high.
REQ-019 Arbitration: one requester valid -> grant it; both valid -> grant the requester not granted last (round-robin).
REQ-020 alu_a/alu_b/alu_op are registers, updated only at acceptance, held stable through EXEC and RESP.
REQ-021 EXEC lasts exactly one cycle; at its closing edge alu_y is captured into rsp_data and state goes to RESP.
REQ-022 RESP: rsp_valid high, rsp_data and rsp_id held stable until rsp_valid and rsp_ready both high, then IDLE on that edge.
REQ-023 Latency: acceptance edge at cycle N -> rsp_valid high in cycle N+2; minimum 3 cycles per operation.
REQ-024 Arithmetic is modulo 2^W; wrap-around on add/sub is passed through unchanged, no carry/borrow output.
REQ-025 Requests arriving during EXEC/RESP wait; requester inputs must stay stable while valid and not ready.
REQ-026 Last-grant pointer updates at acceptance only.

Reset
REQ-027 rst high forces state IDLE immediately, independent of clk.
REQ-028 Reset values: rsp_valid 0, rsp_data 0, rsp_id 0, alu_a 0, alu_b 0, alu_op 00, busy 0, req0_ready/req1_ready 0 during reset.
REQ-029 Last-grant pointer resets to requester 1 so requester 0 wins the first contention.
REQ-030 Reset mid-operation (EXEC or RESP) discards the in-flight operation; no response is produced for it.

Configuration
REQ-031 Macro ALU_SCHED_FIXED_PRIO_EN defined: requester 0 always wins when both valid; last-grant pointer not implemented.
REQ-032 Macro ALU_SCHED_FIXED_PRIO_EN undefined: round-robin per REQ-019 and REQ-026.

Verification
REQ-033 W=4, req0 a=3 b=5 op=00, rsp_ready=1 -> accepted cycle N, rsp_valid cycle N+2, rsp_data=8, rsp_id=0.
REQ-034 req1 a=3 b=5 op=01 -> rsp_data=4'hE (wrap), rsp_id=1; then op=10 -> 1, op=11 -> 7.
REQ-035 Both requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,0,1; with ALU_SCHED_FIXED_PRIO_EN -> 0,0,0,0.
REQ-036 rsp_ready held low 3 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable, both reqN_ready 0, busy 1; response completes when rsp_ready rises.
REQ-037 rst pulsed in EXEC -> all outputs to reset values without clock edge, no response for discarded op; next req0 a=2 b=2 op=00 -> rsp_data=4.
